// File: rtl/mem_march_bist.sv
// March C- style BIST controller for a single-port RAM with registered read data.
// Walks four march elements over the RAM and records pass/fail, the first miscompare and a saturating error count.
module mem_march_bist #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [1:0]            fail_elem,
  output logic [ERR_W-1:0]      err_count
);

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, M3_C, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic [1:0]            fail_elem_q, fail_elem_d;
  logic [ERR_W-1:0]      err_count_q, err_count_d;

  logic                  cmp_en;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [1:0]            cmp_elem;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    err_count_d = err_count_q;
    cmp_en      = 1'b0;
    cmp_exp     = '0;
    cmp_elem    = 2'd0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = M0_W;
          addr_d      = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_elem_d = 2'd0;
          err_count_d = '0;
        end
      end
      M0_W: begin
        if (addr_q == '1) state_d = M1_R;
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
      M1_R: state_d = M1_W;
      M1_W: begin
        cmp_en   = 1'b1;
        cmp_elem = 2'd1;
        // The last ascending address is also the first descending one, so it is held.
        if (addr_q == '1) begin
          state_d = M2_R;
        end else begin
          state_d = M1_R;
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      M2_R: state_d = M2_W;
      M2_W: begin
        cmp_en   = 1'b1;
        cmp_exp  = '1;
        cmp_elem = 2'd2;
        if (addr_q == '0) begin
          state_d = M3_R;
        end else begin
          state_d = M2_R;
          addr_d  = addr_q - ADDR_WIDTH'(1);
        end
      end
      M3_R: state_d = M3_C;
      M3_C: begin
        cmp_en   = 1'b1;
        cmp_elem = 2'd3;
        if (addr_q == '1) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = M3_R;
        end
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase

    // A zero count means no miscompare has been seen yet in this run.
    if (cmp_en && (mem_q != cmp_exp)) begin
      if (err_count_q == '0) begin
        fail_addr_d = addr_q;
        fail_data_d = mem_q;
        fail_elem_d = cmp_elem;
      end
      if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
    end

    if (state_q == M3_C && addr_q == '1) pass_d = (err_count_d == '0);

    mem_we_d   = (state_d == M0_W) || (state_d == M1_W) || (state_d == M2_W);
    mem_data_d = (state_d == M1_W) ? '1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= 2'd0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
      err_count_q <= err_count_d;
    end
  end

  assign mem_data  = mem_data_q;
  assign mem_addr  = addr_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_elem = fail_elem_q;
  assign err_count = err_count_q;

endmodule
